// File: rtl/canny_pkg.sv
// Canny pipeline shared definitions.
// Pixel classes, edge values, hysteresis FSM states and classifier.
package canny_pkg;

  localparam logic [1:0] CLASS_NONE   = 2'b00;
  localparam logic [1:0] CLASS_WEAK   = 2'b01;
  localparam logic [1:0] CLASS_STRONG = 2'b10;

  localparam logic [7:0] EDGE_ON  = 8'hFF;
  localparam logic [7:0] EDGE_OFF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_FLUSH
  } hyst_state_e;

  // Double threshold; an inverted pair leaves no WEAK band.
  function automatic logic [1:0] classify(
    input logic [7:0] p,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    logic [1:0] c;
    c = CLASS_NONE;
    if (p >= hi) begin
      c = CLASS_STRONG;
    end else if (p >= lo && lo <= hi) begin
      c = CLASS_WEAK;
    end
    return c;
  endfunction

endpackage

// File: rtl/edge_class_window.sv
// 3x3 class window with frame-border masking.
// Centre sits one row up and one column left of the incoming pixel.
module edge_class_window #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int COL_W      = 12,
  parameter int ROW_W      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic [1:0]       cls_i,
  input  logic [1:0]       up1_i,
  input  logic [1:0]       up2_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic [COL_W-1:0] col_i,
  output logic             edge_o,
  output logic             first_o,
  output logic             last_col_o
);

  import canny_pkg::*;

  // Index 0 is the newest (bottom) row, index 2 the oldest (top).
  logic [2:0][1:0] right;
  logic [2:0][1:0] mid_q;
  logic [2:0][1:0] left_q;
  logic [1:0]      win [3][3];

  logic [COL_W-1:0] cen_col;
  logic [ROW_W-1:0] cen_row;
  logic             top_m;
  logic             bot_m;
  logic             lft_m;
  logic             rgt_m;
  logic             nb;
  logic             keep;
  logic [1:0]       centre;

  assign right = {up2_i, up1_i, cls_i};

  // Column shift on every pipeline step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mid_q  <= '0;
      left_q <= '0;
    end else if (step_i) begin
      mid_q  <= right;
      left_q <= mid_q;
    end
  end

  // Centre position; a line wrap puts it at the last column two rows up.
  always_comb begin
    cen_col = col_i - 1'b1;
    cen_row = row_i - 1'b1;
    if (col_i == '0) begin
      cen_col = COL_W'(IMG_WIDTH - 1);
      cen_row = row_i - ROW_W'(2);
    end
  end

  assign top_m = (cen_row == '0);
  assign bot_m = (cen_row == ROW_W'(IMG_HEIGHT - 1));
  assign lft_m = (cen_col == '0);
  assign rgt_m = (cen_col == COL_W'(IMG_WIDTH - 1));

  // Assemble the window as [row][col], col 0 leftmost.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = left_q[r];
      win[r][1] = mid_q[r];
      win[r][2] = right[r];
    end
  end

  // Any unmasked STRONG neighbour promotes a WEAK centre.
  always_comb begin
    nb   = 1'b0;
    keep = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        keep = !(r == 1 && c == 1)
             && !(r == 2 && top_m)
             && !(r == 0 && bot_m)
             && !(c == 0 && lft_m)
             && !(c == 2 && rgt_m);
        if (keep && win[r][c] == CLASS_STRONG) begin
          nb = 1'b1;
        end
      end
    end
  end

  assign centre     = mid_q[1];
  assign edge_o     = (centre == CLASS_STRONG)
                    | ((centre == CLASS_WEAK) & nb);
  assign first_o    = top_m & lft_m;
  assign last_col_o = rgt_m;

endmodule

// File: rtl/line_buffer.sv
// One-line delay for the Canny window stages.
// dout_o is the word written LINE_WIDTH enabled cycles earlier.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 1920
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [LINE_WIDTH];
  logic [AW-1:0]         ptr_q;
  logic [AW-1:0]         ptr_d;

  assign dout_o = mem_q[ptr_q];

  // Circular pointer wraps at the line length.
  always_comb begin
    ptr_d = ptr_q + 1'b1;
    if (ptr_q == AW'(LINE_WIDTH - 1)) begin
      ptr_d = '0;
    end
  end

  // Pointer advances once per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  // Storage overwrites the word just read out.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/hysteresis_stage.sv
// Canny double-threshold and single-pass 3x3 hysteresis.
// Streams a 0xFF/0x00 edge map one pixel per input pixel.
module hysteresis_stage #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int COL_W      = 12,
  parameter int ROW_W      = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] thr_low,
  input  logic [7:0] thr_high,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tuser,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tuser,
  output logic       m_tlast,
  input  logic       m_tready
);

  import canny_pkg::*;

  hyst_state_e state_q, state_d;

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       thr_lo_q;
  logic [7:0]       thr_hi_q;

  logic [7:0] tdata_q;
  logic       tvalid_q;
  logic       tuser_q;
  logic       tlast_q;

  logic             out_free;
  logic             acc;
  logic             sof;
  logic             step;
  logic             emit;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] nxt_row;
  logic [COL_W-1:0] nxt_col;
  logic [7:0]       lo_eff;
  logic [7:0]       hi_eff;
  logic [1:0]       cls_in;
  logic [1:0]       up1;
  logic [1:0]       up2;
  logic             edge_bit;
  logic             first_px;
  logic             last_col;
  logic             unused_tlast;

  // Line ends come from the column counter, not from the stream.
  assign unused_tlast = s_tlast;

  assign out_free = ~tvalid_q | m_tready;
  assign s_tready = out_free & (state_q != ST_FLUSH);
  assign acc      = s_tvalid & s_tready;
  assign sof      = acc & s_tuser;
  assign step     = acc | ((state_q == ST_FLUSH) & out_free);

  // An SOF beat is pixel (0,0) whatever the counters held.
  assign cur_row = sof ? '0 : row_q;
  assign cur_col = sof ? '0 : col_q;

  // The SOF pixel is classed with the thresholds it latches.
  assign lo_eff = sof ? thr_low  : thr_lo_q;
  assign hi_eff = sof ? thr_high : thr_hi_q;

  assign cls_in = (state_q == ST_FLUSH) ? CLASS_NONE
                : classify(s_tdata, lo_eff, hi_eff);

  // Raster position of the pixel after the current one.
  always_comb begin
    nxt_col = cur_col + 1'b1;
    nxt_row = cur_row;
    if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
      nxt_col = '0;
      nxt_row = cur_row + 1'b1;
    end
  end

  line_buffer #(
    .DATA_WIDTH (2),
    .LINE_WIDTH (IMG_WIDTH)
  ) u_lb0 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (step),
    .din_i  (cls_in),
    .dout_o (up1)
  );

  line_buffer #(
    .DATA_WIDTH (2),
    .LINE_WIDTH (IMG_WIDTH)
  ) u_lb1 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (step),
    .din_i  (up1),
    .dout_o (up2)
  );

  edge_class_window #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .step_i     (step),
    .cls_i      (cls_in),
    .up1_i      (up1),
    .up2_i      (up2),
    .row_i      (cur_row),
    .col_i      (cur_col),
    .edge_o     (edge_bit),
    .first_o    (first_px),
    .last_col_o (last_col)
  );

  // Frame sequencing: prime two lines, run, then pad out the tail.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    emit    = 1'b0;
    if (step) begin
      if (sof) begin
        state_d = ST_PRIME;
        row_d   = nxt_row;
        col_d   = nxt_col;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            emit = 1'b0;
          end
          ST_PRIME: begin
            row_d = nxt_row;
            col_d = nxt_col;
            if (cur_row == ROW_W'(1) && cur_col == '0) begin
              state_d = ST_RUN;
            end
          end
          ST_RUN: begin
            emit  = 1'b1;
            row_d = nxt_row;
            col_d = nxt_col;
            if (cur_row == ROW_W'(IMG_HEIGHT - 1)
                && cur_col == COL_W'(IMG_WIDTH - 1)) begin
              state_d = ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            emit  = 1'b1;
            row_d = nxt_row;
            col_d = nxt_col;
            if (cur_row == ROW_W'(IMG_HEIGHT + 1)
                && cur_col == '0) begin
              state_d = ST_IDLE;
              row_d   = '0;
              col_d   = '0;
            end
          end
        endcase
      end
    end
  end

  // FSM and raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Thresholds hold for a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_lo_q <= '0;
      thr_hi_q <= '0;
    end else if (sof) begin
      thr_lo_q <= thr_low;
      thr_hi_q <= thr_high;
    end
  end

  // Output register: loads on an emitting step, drains on ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q  <= EDGE_OFF;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (step && emit) begin
      tdata_q  <= edge_bit ? EDGE_ON : EDGE_OFF;
      tvalid_q <= 1'b1;
      tuser_q  <= first_px;
      tlast_q  <= last_col;
    end else if (m_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tuser  = tuser_q;
  assign m_tlast  = tlast_q;

endmodule

// File: tb/tb_hysteresis_stage.sv
// Directed bench for hysteresis_stage on an 8x4 frame.
// Expected edge maps are written out by hand per vector.
module tb_hysteresis_stage;

  import canny_pkg::*;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] thr_low;
  logic [7:0] thr_high;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tuser;
  logic       s_tlast;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tuser;
  logic       m_tlast;
  logic       m_tready;

  always #5 clk = ~clk;

  hysteresis_stage #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .COL_W      (3),
    .ROW_W      (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .thr_low  (thr_low),
    .thr_high (thr_high),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tuser  (s_tuser),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast),
    .m_tready (m_tready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] pix [N];
  logic [9:0] outq [$];
  logic [9:0] expq [$];
  logic       rnd_ready = 1'b0;
  int         stall_viol = 0;
  int         flush_viol = 0;
  int         flush_seen = 0;

  // Downstream ready: always 1, or a coin toss per cycle.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: collect transfers, watch stalls and FLUSH ready.
  initial begin
    logic       stalled;
    logic [9:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled && (!m_tvalid
            || {m_tuser, m_tlast, m_tdata} !== held)) begin
          stall_viol++;
        end
        if (dut.state_q == ST_FLUSH) begin
          flush_seen++;
          if (s_tready) flush_viol++;
        end
        if (m_tvalid && m_tready) begin
          outq.push_back({m_tuser, m_tlast, m_tdata});
        end
        stalled = m_tvalid && !m_tready;
        held    = {m_tuser, m_tlast, m_tdata};
      end
    end
  end

  task automatic send_beat(input logic [7:0] d,
                           input logic u,
                           input logic l);
    int   t;
    logic acc;
    t   = 0;
    acc = 1'b0;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      send_beat(pix[i], i == 0, (i % W) == W - 1);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < N; i++) pix[i] = v;
  endtask

  // Expected frame: background value, optional two forced-on pixels.
  task automatic exp_frame(input logic [7:0] bg,
                           input int on1,
                           input int on2);
    logic [7:0] d;
    for (int i = 0; i < N; i++) begin
      d = (i == on1 || i == on2) ? 8'hFF : bg;
      expq.push_back({i == 0, (i % W) == W - 1, d});
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (outq.size() < expq.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (30) @(negedge clk);
    check({tag, "_count"}, 32'(outq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i),
            (i < outq.size()) ? 32'(outq[i]) : 32'hDEAD,
            32'(expq[i]));
    end
    outq.delete();
    expq.delete();
  endtask

  task automatic hyst_pix();
    fill(8'd0);
    pix[1*W+3] = 8'd80;
    pix[1*W+4] = 8'd150;
    pix[2*W+6] = 8'd80;
  endtask

  initial begin
    rst      = 1'b1;
    thr_low  = 8'd50;
    thr_high = 8'd100;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;

    repeat (2) begin
      @(negedge clk);
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
    end
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tuser_tlast", 32'({m_tuser, m_tlast}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_s_tready", 32'(s_tready), 32'd1);
    check("rel_tvalid", 32'(m_tvalid), 32'd0);
    @(posedge clk);
    #1;

    fill(8'd200);
    exp_frame(8'hFF, -1, -1);
    send_frame(N);
    drain("uniform");
    check("uniform_idle", 32'(dut.state_q), 32'(ST_IDLE));

    hyst_pix();
    exp_frame(8'h00, 11, 12);
    send_frame(N);
    drain("hyst");

    send_beat(8'd200, 1'b0, 1'b0);
    send_beat(8'd200, 1'b0, 1'b1);
    fill(8'd0);
    pix[1*W+7] = 8'd80;
    pix[2*W+0] = 8'd150;
    exp_frame(8'h00, 16, -1);
    send_frame(N);
    drain("border");

    thr_low  = 8'd200;
    thr_high = 8'd100;
    hyst_pix();
    exp_frame(8'h00, 12, -1);
    send_frame(N);
    drain("inverted");
    thr_low  = 8'd50;
    thr_high = 8'd100;

    rnd_ready = 1'b1;
    fill(8'd200);
    exp_frame(8'hFF, -1, -1);
    send_frame(N);
    drain("bp_uniform");
    hyst_pix();
    exp_frame(8'h00, 11, 12);
    send_frame(N);
    drain("bp_hyst");
    rnd_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_stable", 32'(stall_viol), 32'd0);
    check("flush_ready_low", 32'(flush_viol), 32'd0);
    check("flush_visited", 32'(flush_seen > 0), 32'd1);

    fill(8'd200);
    send_frame(13);
    for (int i = 0; i < 4; i++) begin
      expq.push_back({i == 0, 1'b0, 8'hFF});
    end
    hyst_pix();
    exp_frame(8'h00, 11, 12);
    send_frame(N);
    drain("resync");

    fill(8'd200);
    exp_frame(8'hFF, -1, -1);
    for (int i = 0; i < N; i++) begin
      if (i == 10) thr_high = 8'd250;
      send_beat(pix[i], i == 0, (i % W) == W - 1);
    end
    drain("thr_hold");
    exp_frame(8'h00, -1, -1);
    send_frame(N);
    drain("thr_new");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
